// File: rtl/div_iter.sv
// div_iter: radix-2 restoring divider for signed/unsigned operands with divide-by-zero early exit.
// Result layout is {remainder, quotient}; ready_o is held until EX drops start_i.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               dbz_o
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {S_IDLE, S_DBZ, S_ON, S_END} state_t;
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   quo_q, quo_d, dvs_q, dvs_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic               qneg_q, qneg_d, rneg_q, rneg_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d, dbz_q, dbz_d;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs, quo_fix, rem_fix;
    logic [WIDTH:0]     tmp, diff;
    // MIN_INT magnitude is its own bit pattern, which is the correct unsigned value.
    assign a_neg   = signed_div_i & opdata1_i[WIDTH-1];
    assign b_neg   = signed_div_i & opdata2_i[WIDTH-1];
    assign a_abs   = a_neg ? -opdata1_i : opdata1_i;
    assign b_abs   = b_neg ? -opdata2_i : opdata2_i;
    assign tmp     = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign diff    = tmp - {1'b0, dvs_q};
    assign quo_fix = qneg_q ? -quo_q : quo_q;
    assign rem_fix = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        ready_d  = ready_q;
        dbz_d    = dbz_q;
        case (state_q)
            S_IDLE: if (start_i) begin
                if (opdata2_i == '0) begin
                    state_d = S_DBZ;
                end else begin
                    state_d = S_ON;
                    cnt_d   = '0;
                    quo_d   = a_abs;
                    dvs_d   = b_abs;
                    rem_d   = '0;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                end
            end
            S_DBZ: begin
                state_d  = annul_i ? S_IDLE : S_END;
                result_d = '0;
                ready_d  = !annul_i;
                dbz_d    = !annul_i;
            end
            S_ON: if (annul_i) begin
                state_d = S_IDLE;
            end else if (cnt_q != CW'(WIDTH)) begin
                rem_d = diff[WIDTH] ? tmp : diff;
                quo_d = {quo_q[WIDTH-2:0], !diff[WIDTH]};
                cnt_d = cnt_q + CW'(1);
            end else begin
                result_d = {rem_fix, quo_fix};
                ready_d  = 1'b1;
                state_d  = S_END;
            end
            default: if (!start_i) begin
                state_d  = S_IDLE;
                result_d = '0;
                ready_d  = 1'b0;
                dbz_d    = 1'b0;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            dbz_q    <= dbz_d;
        end
    end
    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign dbz_o    = dbz_q;
    assign busy_o   = (state_q == S_DBZ) || (state_q == S_ON);
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed checks of div_iter at WIDTH=32 and WIDTH=8.
module tb_div_iter;
    logic        clk = 1'b0;
    logic        rst, sg, start, annul;
    logic [31:0] op1, op2;
    logic [63:0] res;
    logic        ready, busy, dbz;
    logic        b_sg, b_start, b_annul;
    logic [7:0]  b_op1, b_op2;
    logic [15:0] b_res;
    logic        b_ready, b_busy, b_dbz;
    int          total = 0, bad = 0;
    always #5 clk = ~clk;
    div_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .signed_div_i(sg), .opdata1_i(op1), .opdata2_i(op2),
        .start_i(start), .annul_i(annul), .result_o(res), .ready_o(ready),
        .busy_o(busy), .dbz_o(dbz)
    );
    div_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .signed_div_i(b_sg), .opdata1_i(b_op1), .opdata2_i(b_op2),
        .start_i(b_start), .annul_i(b_annul), .result_o(b_res), .ready_o(b_ready),
        .busy_o(b_busy), .dbz_o(b_dbz)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    // Called at a negedge; lat is the edge count after E0 at which ready_o first rises.
    task automatic run(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] er, input logic ed, input int lat);
        int n = 1;
        int nb = 0;
        sg = s; op1 = a; op2 = b; start = 1'b1;
        @(posedge clk);
        #1 op1 = 32'hFFFF_FFFF; op2 = 32'h5; sg = ~s;
        @(negedge clk);
        if (busy) nb++;
        while (!ready && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (busy) nb++;
        end
        chk({tag, " latency"}, 64'(n), 64'(lat + 1));
        chk({tag, " busy cycles"}, 64'(nb), 64'(lat));
        chk({tag, " result"}, res, er);
        chk({tag, " dbz"}, 64'(dbz), 64'(ed));
        annul = 1'b1;
        @(negedge clk);
        chk({tag, " hold ready"}, 64'(ready), 64'd1);
        chk({tag, " hold result"}, res, er);
        annul = 1'b0; start = 1'b0;
        @(negedge clk);
        chk({tag, " cleared"}, {res[61:0], ready, dbz}, 64'd0);
    endtask
    initial begin
        int n;
        rst = 1'b1; sg = 1'b0; start = 1'b0; annul = 1'b0; op1 = '0; op2 = '0;
        b_sg = 1'b0; b_start = 1'b0; b_annul = 1'b0; b_op1 = '0; b_op2 = '0;
        repeat (2) @(negedge clk);
        chk("reset outputs", {res[60:0], ready, busy, dbz}, 64'd0);
        rst = 1'b0;
        run("u100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 33);
        run("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 33);
        run("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 1'b0, 33);
        run("smin/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1'b0, 33);
        run("umax/16", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 1'b0, 33);
        run("dbz", 1'b1, 32'd55, 32'd0, 64'd0, 1'b1, 1);
        sg = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        chk("annul idle", {res[61:0], ready, busy}, 64'd0);
        annul = 1'b0;
        run("after annul", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 1'b0, 33);
        sg = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("busy before rst", 64'(busy), 64'd1);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("mid rst", {res[60:0], ready, busy, dbz}, 64'd0);
        rst = 1'b0;
        b_op1 = 8'd200; b_op2 = 8'd3; b_start = 1'b1;
        n = 0;
        @(negedge clk);
        while (!b_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("w8 latency", 64'(n), 64'd9);
        chk("w8 result", 64'(b_res), {48'd0, 8'd2, 8'd66});
        chk("w8 dbz", 64'(b_dbz), 64'd0);
        b_start = 1'b0;
        @(negedge clk);
        chk("w8 cleared", {46'd0, b_res, b_ready, b_busy}, 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
